// File: rtl/ssp_peer.sv
// Serial-side link partner for the 8-bit synchronous serial port: deserialises frames the port
// transmits onto a valid/ready output and serialises valid/ready input words toward the port.
module ssp_peer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              PCLK,
  input  logic              CLEAR,
  input  logic              SSPCLKOUT,
  input  logic              SSPFSSOUT,
  input  logic              SSPTXD,
  input  logic              SSPOE_B,
  output logic              SSPCLKIN,
  output logic              SSPFSSIN,
  output logic              SSPRXD,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              frame_err
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  localparam logic RX_IDLE = 1'b0;
  localparam logic RX_BITS = 1'b1;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_WAIT = 2'd1;
  localparam logic [1:0] TX_FSS  = 2'd2;
  localparam logic [1:0] TX_BITS = 2'd3;

  // ---------------------------------------------------------------- receive path
  logic              clk_q;
  logic              rise;
  logic              rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_shift;

  assign rise = SSPCLKOUT & ~clk_q;

  always_comb begin
    rx_shift = MSB_FIRST ? {rx_sr[DATA_W-2:0], SSPTXD} : {SSPTXD, rx_sr[DATA_W-1:1]};
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      clk_q      <= 1'b0;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_sr      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_q <= SSPCLKOUT;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (rise) begin
        case (rx_state)
          RX_IDLE: begin
            if (SSPFSSOUT) begin
              rx_state <= RX_BITS;
              rx_cnt   <= '0;
            end
          end
          default: begin
            if (SSPOE_B || (SSPFSSOUT && rx_cnt != LAST)) begin
              // A stray FSS doubles as the start of a fresh frame.
              frame_err <= 1'b1;
              rx_cnt    <= '0;
              rx_state  <= SSPFSSOUT ? RX_BITS : RX_IDLE;
            end else begin
              rx_sr <= rx_shift;
              if (rx_cnt == LAST) begin
                if (rx_valid && !rx_ready) begin
                  rx_overrun <= 1'b1;
                end else begin
                  rx_data  <= rx_shift;
                  rx_valid <= 1'b1;
                end
                rx_cnt   <= '0;
                rx_state <= SSPFSSOUT ? RX_BITS : RX_IDLE;
              end else begin
                rx_cnt <= rx_cnt + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------- transmit path
  logic              ck_q;
  logic              live_q;
  logic              pend_q;
  logic [1:0]        tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic              fss_q;
  logic              rxd_q;
  logic              accept;
  logic              tx_bit;
  logic [DATA_W-1:0] tx_next_sr;

  // pend_q keeps a word taken early in the last slot from being accepted twice.
  assign tx_ready = live_q & ((tx_state == TX_IDLE) |
                              ((tx_state == TX_BITS) & (tx_cnt == LAST) & ~pend_q));
  assign accept   = tx_valid & tx_ready;

  always_comb begin
    tx_bit     = MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0];
    tx_next_sr = MSB_FIRST ? (tx_sr << 1) : (tx_sr >> 1);
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      ck_q     <= 1'b0;
      live_q   <= 1'b0;
      pend_q   <= 1'b0;
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_sr    <= '0;
      fss_q    <= 1'b0;
      rxd_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      ck_q   <= ~ck_q;
      if (accept) begin
        tx_sr <= tx_data;
        if (tx_state == TX_IDLE) tx_state <= TX_WAIT;
        else pend_q <= 1'b1;
      end
      // ck_q high means this edge drives SSPCLKIN 1->0: the only edge outputs may move on.
      if (ck_q) begin
        case (tx_state)
          TX_WAIT: begin
            fss_q    <= 1'b1;
            rxd_q    <= 1'b0;
            tx_state <= TX_FSS;
          end
          TX_FSS: begin
            fss_q    <= 1'b0;
            rxd_q    <= tx_bit;
            tx_sr    <= tx_next_sr;
            tx_cnt   <= '0;
            tx_state <= TX_BITS;
          end
          TX_BITS: begin
            if (tx_cnt == LAST) begin
              rxd_q  <= 1'b0;
              pend_q <= 1'b0;
              if (pend_q || accept) begin
                fss_q    <= 1'b1;
                tx_state <= TX_FSS;
              end else begin
                tx_state <= TX_IDLE;
              end
            end else begin
              rxd_q  <= tx_bit;
              tx_sr  <= tx_next_sr;
              tx_cnt <= tx_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SSPCLKIN = ck_q;
  assign SSPFSSIN = fss_q;
  assign SSPRXD   = rxd_q;

endmodule
